// File: rtl/decode_stage.sv
// Decode stage: 2-entry skid FIFO of decoded fields with a RUN/DRAIN/HALTED
// control FSM and a saturating issued-instruction counter.
module decode_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [19:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_op,
    output logic [5:0]       out_src1,
    output logic [5:0]       out_src2,
    output logic [5:0]       out_dst,
    input  logic             resume,
    output logic             halted,
    output logic [CNT_W-1:0] issued_cnt
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    // Field order matches the instruction word, so a word casts straight in.
    typedef struct packed {
        logic [1:0] op;
        logic [5:0] src1;
        logic [5:0] src2;
        logic [5:0] dst;
    } entry_t;

    localparam logic [1:0] OP_HALT = 2'b11;

    state_t     state;
    entry_t     fifo_q [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    logic       accept;
    logic       issue;
    logic       is_halt;
    logic       push;
    logic [1:0] count_after_issue;
    entry_t     head;

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready          = (state == RUN) && (count != 2'd2);
    assign out_valid         = (count != 2'd0);
    assign accept            = in_valid && in_ready;
    assign issue             = out_valid && out_ready;
    assign is_halt           = (in_instr[19:18] == OP_HALT);
    assign push              = accept && !is_halt;
    assign count_after_issue = count - {1'b0, issue};

    assign head     = fifo_q[rd_ptr];
    assign out_op   = head.op;
    assign out_src1 = head.src1;
    assign out_src2 = head.src2;
    assign out_dst  = head.dst;

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            // NOTE: the two entries are reset so out_* read 0 after reset;
            // larger buffers would normally be left unreset.
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= entry_t'(in_instr);
                wr_ptr         <= ~wr_ptr;
            end
            if (issue) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, issue})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt <= '0;
        end else if (issue && (issued_cnt != {CNT_W{1'b1}})) begin
            issued_cnt <= issued_cnt + 1'b1;
        end
    end

    // halted is loaded alongside state so it is a flop, not a decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            halted <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (accept && is_halt) begin
                        if (count_after_issue != 2'd0) begin
                            state <= DRAIN;
                        end else begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if ((issue && count == 2'd1) || count == 2'd0) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    if (resume) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the issued-instruction counter.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, upstream instruction word present.
REQ-005 SHALL have port in_instr, input, 20 bits, instruction word: [19:18] op, [17:12] src1, [11:6] src2, [5:0] dst.
REQ-006 SHALL have port in_ready, output, 1 bit, stage accepts in_instr this cycle.
REQ-007 SHALL have port out_valid, output, 1 bit, decoded instruction present at the outputs.
REQ-008 SHALL have port out_ready, input, 1 bit, downstream execute stage consumes this cycle.
REQ-009 SHALL have ports out_op (2 bits), out_src1, out_src2 and out_dst (6 bits each), all outputs, decoded fields of the head entry.
REQ-010 SHALL have port resume, input, 1 bit, single-cycle pulse that restarts fetch after a halt.
REQ-011 SHALL have port halted, output, 1 bit, high while in state HALTED.
REQ-012 SHALL have port issued_cnt, output, CNT_W bits, number of instructions handed downstream.

Function
REQ-013 SHALL buffer decoded instructions in a 2-entry FIFO of registered entries, holding op, src1, src2 and dst.
REQ-014 SHALL treat in_valid && in_ready as accept, and out_valid && out_ready as issue.
REQ-015 SHALL drive in_ready = (state == RUN) && (fifo occupancy < 2), with no combinational path from out_ready.
REQ-016 SHALL drive out_valid = (occupancy > 0); out_* SHALL reflect the oldest entry and stay stable while out_valid && !out_ready.
REQ-017 SHALL push an accepted word into the FIFO when op is 00, 01 or 10, visible at the outputs no earlier than the next cycle (1-cycle minimum latency, no bypass).
REQ-018 SHALL treat op 11 as HALT: accepted, never pushed, never issued, never counted.
REQ-019 SHALL, on simultaneous accept and issue, keep occupancy unchanged and preserve FIFO order.
REQ-020 SHALL implement FSM states RUN, DRAIN and HALTED.
REQ-021 In RUN, accepting HALT SHALL move to DRAIN if occupancy after this cycle's issue is nonzero, otherwise directly to HALTED.
REQ-022 In DRAIN, in_ready SHALL be 0; the FSM SHALL move to HALTED in the cycle after the last entry issues.
REQ-023 In HALTED, a resume pulse SHALL move the FSM to RUN in the next cycle; resume SHALL be ignored in RUN and DRAIN.
REQ-024 SHALL increment issued_cnt by 1 on each issue, saturating at 2^CNT_W-1 (no wrap).
REQ-025 SHALL keep halted = (state == HALTED), registered.

Reset
REQ-026 With rst high at a clock edge, the block SHALL clear FIFO occupancy and pointers, set the FSM to RUN and set issued_cnt to 0, overriding any simultaneous accept, issue or resume.
REQ-027 During and immediately after reset, the outputs SHALL be out_valid=0, in_ready=1 and halted=0; out_op, out_src1, out_src2 and out_dst SHALL be 0.
REQ-028 Reset asserted mid-DRAIN or mid-HALTED SHALL discard buffered entries with no issue.

Verification
REQ-029 Stream 20'b00_000000_000001_000010 and 20'b01_001001_001010_001011 with out_ready=1 -> issue on consecutive cycles starting 1 cycle after the first accept, with fields op=0/src1=0/src2=1/dst=2, then op=1/src1=9/src2=10/dst=11; issued_cnt=2.
REQ-030 Hold out_ready=0 while offering 3 words -> in_ready drops after 2 accepts and out_* stay stable; raise out_ready -> 2 issues in order, then the third word is accepted.
REQ-031 Two ALU words buffered, out_ready=0, then 20'b11_000000_000000_000000 -> HALT accepted, in_ready=0 and halted=0 (DRAIN); raise out_ready -> 2 issues, then halted=1 one cycle later.
REQ-032 HALT offered with an empty FIFO -> halted=1 the next cycle; resume pulse -> halted=0 and in_ready=1 next cycle; a resume pulse while in RUN has no effect.
REQ-033 CNT_W=2, issue 5 instructions -> issued_cnt reads 1,2,3,3,3.
REQ-034 Assert rst while 2 entries are buffered in DRAIN -> the next cycle shows out_valid=0, in_ready=1, halted=0 and issued_cnt=0.
